fir_coe_ctrl: RTL and testbench



---
 rtl/fir_coe_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fir_coe_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coe_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : fir_coe_ctrl
// Brief  : Double-buffered FIR coefficient reload with swap-on-idle.
// Rev    : 1.0  initial release
// ============================================================================
module fir_coe_ctrl #(
    parameter int COE_WIDTH = 16,
    parameter int COE_NUM   = 29
) (
    input  logic                           clk_i,
    input  logic                           arstn_i,
    input  logic [COE_WIDTH-1:0]           s_coe_tdata,
    input  logic                           s_coe_tvalid,
    output logic                           s_coe_tready,
    input  logic                           s_coe_tlast,
    input  logic                           fir_busy_i,
    output logic                           fir_hold_o,
    output logic [COE_NUM*COE_WIDTH-1:0]   coe_o,
    output logic                           bank_sel_o,
    output logic                           swap_done_o,
    output logic                           load_err_o,
    input  logic                           err_clr_i
);

    localparam int c_CNT_W = (COE_NUM > 1) ? $clog2(COE_NUM) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(COE_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_IDLE = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_tready;
    logic                 r_hold;
    logic                 r_bank_sel;
    logic                 r_swap_done;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_wr_en;
    logic                 w_at_last;
    logic                 w_err_set;

    assign w_accept  = s_coe_tvalid & r_tready;
    assign w_at_last = (r_cnt == c_LAST);
    assign w_wr_en   = w_accept & ((r_state == ST_IDLE) | (r_state == ST_LOAD));

    // Framing error: tlast on the first beat, or tlast disagreeing with the final tap.
    assign w_err_set = w_accept & (((r_state == ST_IDLE) & s_coe_tlast) |
                                   ((r_state == ST_LOAD) & (s_coe_tlast != w_at_last)));

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tready    <= 1'b0;
            r_hold      <= 1'b0;
            r_bank_sel  <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        if (s_coe_tlast) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt   <= c_CNT_W'(1);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_at_last) begin
                            r_cnt <= '0;
                            if (s_coe_tlast) begin
                                r_state  <= ST_WAIT_IDLE;
                                r_tready <= 1'b0;
                                r_hold   <= 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end else if (s_coe_tlast) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_accept && s_coe_tlast) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!fir_busy_i) begin
                        r_bank_sel  <= ~r_bank_sel;
                        r_swap_done <= 1'b1;
                        r_hold      <= 1'b0;
                        r_tready    <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Set has priority over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_set | (r_err & ~err_clr_i);
        end
    end

    for (genvar i = 0; i < COE_NUM; i++) begin : g_tap
        localparam logic [c_CNT_W-1:0] c_IDX = c_CNT_W'(i);
        logic [COE_WIDTH-1:0] r_tap0;
        logic [COE_WIDTH-1:0] r_tap1;

        // Only the shadow bank (the one not selected) is ever written.
        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                r_tap0 <= '0;
                r_tap1 <= '0;
            end else if (w_wr_en && (r_cnt == c_IDX)) begin
                if (r_bank_sel) begin
                    r_tap0 <= s_coe_tdata;
                end else begin
                    r_tap1 <= s_coe_tdata;
                end
            end
        end

        assign coe_o[i*COE_WIDTH +: COE_WIDTH] = r_bank_sel ? r_tap1 : r_tap0;
    end

    assign s_coe_tready = r_tready;
    assign fir_hold_o   = r_hold;
    assign bank_sel_o   = r_bank_sel;
    assign swap_done_o  = r_swap_done;
    assign load_err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_coe_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_fir_coe_ctrl
// Brief  : Directed and random coefficient-set loads against a set-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fir_coe_ctrl;

    localparam int NUM = 4;
    localparam int W   = 16;

    logic               clk_i = 1'b0;
    logic               arstn_i = 1'b0;
    logic [W-1:0]       s_coe_tdata = '0;
    logic               s_coe_tvalid = 1'b0;
    logic               s_coe_tready;
    logic               s_coe_tlast = 1'b0;
    logic               fir_busy_i = 1'b0;
    logic               fir_hold_o;
    logic [NUM*W-1:0]   coe_o;
    logic               bank_sel_o;
    logic               swap_done_o;
    logic               load_err_o;
    logic               err_clr_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Set-level model: active coefficients, active bank index, sticky error.
    logic [W-1:0] m_active [NUM];
    logic         m_sel;
    logic         m_err;
    logic [W-1:0] set_q [$];

    fir_coe_ctrl #(.COE_WIDTH(W), .COE_NUM(NUM)) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .s_coe_tdata  (s_coe_tdata),
        .s_coe_tvalid (s_coe_tvalid),
        .s_coe_tready (s_coe_tready),
        .s_coe_tlast  (s_coe_tlast),
        .fir_busy_i   (fir_busy_i),
        .fir_hold_o   (fir_hold_o),
        .coe_o        (coe_o),
        .bank_sel_o   (bank_sel_o),
        .swap_done_o  (swap_done_o),
        .load_err_o   (load_err_o),
        .err_clr_i    (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [NUM*W-1:0] obs, input logic [NUM*W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM*W-1:0] exp_coe();
        logic [NUM*W-1:0] v;
        for (int i = 0; i < NUM; i++) v[i*W +: W] = m_active[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) m_active[i] = '0;
        m_sel = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_coe"},   coe_o, exp_coe());
        chk({tag, "_sel"},   bank_sel_o, m_sel);
        chk({tag, "_err"},   load_err_o, m_err);
        chk({tag, "_hold"},  fir_hold_o, 1'b0);
        chk({tag, "_swap"},  swap_done_o, 1'b0);
        chk({tag, "_ready"}, s_coe_tready, 1'b1);
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        int   t;
        logic acc;
        t = 0;
        s_coe_tdata  = d;
        s_coe_tlast  = last;
        s_coe_tvalid = 1'b1;
        do begin
            acc = s_coe_tready;
            tick();
            t++;
        end while (!acc && t < 20);
        chk("beat_accept", acc, 1'b1);
        s_coe_tvalid = 1'b0;
        s_coe_tlast  = 1'b0;
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        m_err = 1'b0;
        chk("err_clear", load_err_o, 1'b0);
    endtask

    // Sends set_q as one framed set; a set is valid iff it has exactly NUM beats.
    task automatic send_set(input int busy_cycles, input bit clr_last);
        int n;
        int g;
        n = set_q.size();
        fir_busy_i = (busy_cycles > 0);
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, 2);
            repeat (g) tick();
            if (i == n - 1) err_clr_i = clr_last;
            send_beat(set_q[i], i == n - 1);
            err_clr_i = 1'b0;
        end
        if (n == NUM) begin
            chk("hold_rise", fir_hold_o, 1'b1);
            chk("ready_low", s_coe_tready, 1'b0);
            for (int k = 0; k < busy_cycles; k++) begin
                chk("hold_busy", fir_hold_o, 1'b1);
                chk("coe_held", coe_o, exp_coe());
                chk("no_swap", swap_done_o, 1'b0);
                tick();
            end
            fir_busy_i = 1'b0;
            chk("hold_last", fir_hold_o, 1'b1);
            chk("coe_old", coe_o, exp_coe());
            tick();
            for (int i = 0; i < NUM; i++) m_active[i] = set_q[i];
            m_sel = ~m_sel;
            chk("swap_pulse", swap_done_o, 1'b1);
            chk("swap_sel", bank_sel_o, m_sel);
            chk("swap_coe", coe_o, exp_coe());
            chk("swap_hold", fir_hold_o, 1'b0);
            chk("swap_ready", s_coe_tready, 1'b1);
            tick();
            chk("swap_once", swap_done_o, 1'b0);
        end else begin
            m_err = 1'b1;
            check_idle_outputs("frame_err");
            clear_err();
        end
        fir_busy_i = 1'b0;
    endtask

    task automatic load_list(input int a, input int b, input int c, input int d, input int e, input int f, input int len);
        int v [6];
        v = '{a, b, c, d, e, f};
        set_q.delete();
        for (int i = 0; i < len; i++) set_q.push_back(W'(v[i]));
    endtask

    initial begin
        model_reset();
        // Reset and first-cycle tready behaviour
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_coe", coe_o, '0);
        chk("rst_sel", bank_sel_o, 1'b0);
        chk("rst_hold", fir_hold_o, 1'b0);
        chk("rst_swap", swap_done_o, 1'b0);
        chk("rst_err", load_err_o, 1'b0);
        chk("rst_ready", s_coe_tready, 1'b0);
        arstn_i = 1'b1;
        chk("rel_ready0", s_coe_tready, 1'b0);
        tick();
        chk("rel_ready1", s_coe_tready, 1'b1);

        // Basic load, FIR idle
        load_list(1, 2, 3, 4, 0, 0, 4);
        send_set(0, 1'b0);
        chk("basic_sel", bank_sel_o, 1'b1);

        // Load with FIR busy 10 cycles after last beat
        load_list(21, 22, 23, 24, 0, 0, 4);
        send_set(10, 1'b0);

        // Short set, with a clear colliding with the error (set wins)
        load_list(5, 6, 0, 0, 0, 0, 2);
        send_set(0, 1'b1);

        // Long set, then a valid set
        load_list(7, 8, 9, 10, 11, 12, 6);
        send_set(0, 1'b0);
        load_list(1, 2, 3, 4, 0, 0, 4);
        send_set(0, 1'b0);

        // Single-beat set framed as last on the first tap
        load_list(99, 0, 0, 0, 0, 0, 1);
        send_set(0, 1'b0);

        // Back-to-back sets A then B
        load_list(1, 2, 3, 4, 0, 0, 4);
        send_set(0, 1'b0);
        load_list(5, 6, 7, 8, 0, 0, 4);
        send_set(int'($urandom_range(0, 3)), 1'b0);

        // Randomized sets of random length
        for (int r = 0; r < 12; r++) begin
            int len;
            len = $urandom_range(1, 6);
            set_q.delete();
            for (int i = 0; i < len; i++) set_q.push_back(W'($urandom));
            send_set(int'($urandom_range(0, 3)), 1'b0);
        end

        // Asynchronous reset in the middle of a load
        send_beat(16'h0aa1, 1'b0);
        send_beat(16'h0aa2, 1'b0);
        arstn_i = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_coe", coe_o, '0);
        chk("mid_rst_sel", bank_sel_o, 1'b0);
        chk("mid_rst_hold", fir_hold_o, 1'b0);
        chk("mid_rst_swap", swap_done_o, 1'b0);
        chk("mid_rst_err", load_err_o, 1'b0);
        chk("mid_rst_ready", s_coe_tready, 1'b0);
        tick();
        arstn_i = 1'b1;
        tick();
        load_list(31, 32, 33, 34, 0, 0, 4);
        send_set(0, 1'b0);
        chk("post_rst_sel", bank_sel_o, 1'b1);

        // Final load must land in the old active bank and swap back
        load_list(41, 42, 43, 44, 0, 0, 4);
        send_set(2, 1'b0);
        check_idle_outputs("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
